gb_cpu_interrupt_ctrl: RTL and testbench

//  Parametrised interrupt controller that replaces the CPU-top IME/IF/IE glue.

---
 rtl/gb_cpu_common_pkg.sv | 23 ++
 rtl/gb_cpu_irq_prio_enc.sv | 29 ++
 rtl/gb_cpu_interrupt_ctrl.sv | 168 ++++++++++++++++
 tb/tb_gb_cpu_interrupt_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/gb_cpu_common_pkg.sv
// Shared types and constants for the gb_cpu interrupt path.
//   irq_state_t            : dispatch FSM states
//   IF_ADDR_DEFAULT        : default bus address of the IF register
//   IE_ADDR_DEFAULT        : default bus address of the IE register
//   VECTOR_BASE_DEFAULT    : default vector for interrupt line 0
//   idx_width()            : index width for an N-entry priority encoder
package gb_cpu_common_pkg;

   typedef enum logic [0:0] {
      IRQ_IDLE = 1'b0,
      IRQ_PUSH = 1'b1
   } irq_state_t;

   localparam logic [15:0] IF_ADDR_DEFAULT     = 16'hFF0F;
   localparam logic [15:0] IE_ADDR_DEFAULT     = 16'hFFFF;
   localparam logic [15:0] VECTOR_BASE_DEFAULT = 16'h0040;

   // A one-entry encoder still needs a one-bit index port.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gb_cpu_irq_prio_enc.sv
// Combinational priority encoder: lowest set bit wins.
// Ports:
//   req   in  N       request vector, bit 0 highest priority
//   idx   out IDX_W   index of the lowest set bit (0 when none)
//   valid out 1       at least one request bit is set
module gb_cpu_irq_prio_enc
   import gb_cpu_common_pkg::*;
#(
   parameter int N = 5,
   localparam int IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   // Scan downward so the last match written is the lowest index.
   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/gb_cpu_interrupt_ctrl.sv
// Interrupt controller for the gb_cpu: owns IF, IE and IME, handles the
// delayed EI, and runs the two-step dispatch handshake with the scheduler.
// Ports:
//   clk, reset          machine clock, synchronous active-high reset
//   irq_i               peripheral request lines, sampled every cycle
//   bus_addr_i/wdata_i/we_i   CPU bus write side
//   bus_rdata_o         combinational read data (IF/IE, else 8'hFF)
//   bus_hit_o           address decodes to IF or IE
//   ei_req_i/di_req_i/reti_req_i   IME control from the instruction stream
//   irq_pending_o       IME and an enabled flag: dispatch next
//   wake_o              any enabled flag, ignoring IME (HALT exit)
//   dispatch_i          scheduler began the ISR entry (PC push)
//   vec_req_i           scheduler samples vector_o this cycle
//   vector_o            ISR target, non-zero only on a hitting vec_req_i
//   ime_o               current IME
//   irq_state           dispatch FSM state (observability)
//
// Handshake: dispatch_i is accepted only in IDLE while irq_pending_o is
// high; the FSM then sits in PUSH until vec_req_i, where the priority
// decision is taken from IF&IE in that same cycle (not at dispatch time).
module gb_cpu_interrupt_ctrl
   import gb_cpu_common_pkg::*;
#(
   parameter int          NUM_IRQ       = 5,
   parameter logic [15:0] VECTOR_BASE   = VECTOR_BASE_DEFAULT,
   parameter int          VECTOR_STRIDE = 8,
   parameter logic [15:0] IF_ADDR       = IF_ADDR_DEFAULT,
   parameter logic [15:0] IE_ADDR       = IE_ADDR_DEFAULT,
   parameter int          EI_DELAY      = 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] irq_i,
   input  logic [15:0]        bus_addr_i,
   input  logic [7:0]         bus_wdata_i,
   input  logic               bus_we_i,
   output logic [7:0]         bus_rdata_o,
   output logic               bus_hit_o,
   input  logic               ei_req_i,
   input  logic               di_req_i,
   input  logic               reti_req_i,
   output logic               irq_pending_o,
   output logic               wake_o,
   input  logic               dispatch_i,
   input  logic               vec_req_i,
   output logic [15:0]        vector_o,
   output logic               ime_o,
   output irq_state_t         irq_state
);

   localparam int IDX_W = idx_width(NUM_IRQ);
   localparam int CNT_W = (EI_DELAY < 2) ? 1 : $clog2(EI_DELAY + 1);

   logic [NUM_IRQ-1:0] if_q, if_d;
   logic [7:0]         ie_q;
   logic               ime_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               counting_q;
   irq_state_t         state_q, state_d;

   logic [NUM_IRQ-1:0] active;
   logic [IDX_W-1:0]   hit_idx;
   logic               hit_valid;
   logic               if_sel, ie_sel;
   logic               accept;
   logic               clr_en;
   logic [NUM_IRQ-1:0] clr_mask;

   assign active        = if_q & ie_q[NUM_IRQ-1:0];
   assign wake_o        = |active;
   assign irq_pending_o = ime_q & wake_o;
   assign ime_o         = ime_q;
   assign irq_state     = state_q;

   gb_cpu_irq_prio_enc #(.N(NUM_IRQ)) u_prio (
      .req   (active),
      .idx   (hit_idx),
      .valid (hit_valid)
   );

   // Bus decode and read mux; unimplemented IF bits read as 1.
   assign if_sel    = (bus_addr_i == IF_ADDR);
   assign ie_sel    = (bus_addr_i == IE_ADDR);
   assign bus_hit_o = if_sel | ie_sel;

   always_comb begin
      bus_rdata_o = 8'hFF;
      if (if_sel) begin
         bus_rdata_o[NUM_IRQ-1:0] = if_q;
      end else if (ie_sel) begin
         bus_rdata_o = ie_q;
      end
   end

   assign accept = (state_q == IRQ_IDLE) & dispatch_i & irq_pending_o;

   // FSM next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IRQ_IDLE: if (accept)    state_d = IRQ_PUSH;
         IRQ_PUSH: if (vec_req_i) state_d = IRQ_IDLE;
         default:                 state_d = IRQ_IDLE;
      endcase
   end

   // FSM outputs: vector and the IF clear that goes with it
   always_comb begin
      vector_o = 16'h0000;
      clr_en   = 1'b0;
      if (state_q == IRQ_PUSH && vec_req_i && hit_valid) begin
         vector_o = VECTOR_BASE + 16'(hit_idx) * 16'(VECTOR_STRIDE);
         clr_en   = 1'b1;
      end
   end

   always_comb begin
      clr_mask = '0;
      if (clr_en) clr_mask[hit_idx] = 1'b1;
   end

   // IF update order: bus write, then dispatch clear, then new requests,
   // so a request always wins against both a write and a clear.
   always_comb begin
      if_d = if_q;
      if (bus_we_i && if_sel) if_d = bus_wdata_i[NUM_IRQ-1:0];
      if_d = (if_d & ~clr_mask) | irq_i;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         if_q       <= '0;
         ie_q       <= 8'h00;
         ime_q      <= 1'b0;
         cnt_q      <= '0;
         counting_q <= 1'b0;
         state_q    <= IRQ_IDLE;
      end else begin
         if_q    <= if_d;
         state_q <= state_d;
         if (bus_we_i && ie_sel) ie_q <= bus_wdata_i;

         // DI (or an accepted dispatch) dominates every other IME source.
         if (di_req_i || accept) begin
            ime_q      <= 1'b0;
            counting_q <= 1'b0;
         end else begin
            if (ei_req_i) begin
               if (EI_DELAY == 0) begin
                  ime_q <= 1'b1;
               end else begin
                  cnt_q      <= CNT_W'(EI_DELAY);
                  counting_q <= 1'b1;
               end
            end else if (counting_q) begin
               if (cnt_q == CNT_W'(1)) begin
                  ime_q      <= 1'b1;
                  counting_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            if (reti_req_i) ime_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_gb_cpu_interrupt_ctrl.sv
module tb_gb_cpu_interrupt_ctrl;
   import gb_cpu_common_pkg::*;

   localparam int          N        = 5;
   localparam logic [15:0] VBASE    = 16'h0040;
   localparam int          VSTRIDE  = 8;
   localparam logic [15:0] A_IF     = 16'hFF0F;
   localparam logic [15:0] A_IE     = 16'hFFFF;
   localparam int          EID      = 1;
   localparam logic [7:0]  MASK     = 8'((1 << N) - 1);

   typedef struct packed {
      logic [7:0]  rdata;
      logic        hit;
      logic        pending;
      logic        wake;
      logic        ime;
      logic [15:0] vector;
      logic        state;
   } exp_t;
   localparam int W = $bits(exp_t);

   // clock / reset
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               reset;
   logic [N-1:0]       irq;
   logic [15:0]        bus_addr;
   logic [7:0]         bus_wdata;
   logic               bus_we;
   logic [7:0]         bus_rdata;
   logic               bus_hit;
   logic               ei_req, di_req, reti_req;
   logic               irq_pending, wake;
   logic               dispatch, vec_req;
   logic [15:0]        vector;
   logic               ime;
   irq_state_t         irq_state;

   gb_cpu_interrupt_ctrl #(
      .NUM_IRQ(N), .VECTOR_BASE(VBASE), .VECTOR_STRIDE(VSTRIDE),
      .IF_ADDR(A_IF), .IE_ADDR(A_IE), .EI_DELAY(EID)
   ) dut (
      .clk(clk), .reset(reset), .irq_i(irq),
      .bus_addr_i(bus_addr), .bus_wdata_i(bus_wdata), .bus_we_i(bus_we),
      .bus_rdata_o(bus_rdata), .bus_hit_o(bus_hit),
      .ei_req_i(ei_req), .di_req_i(di_req), .reti_req_i(reti_req),
      .irq_pending_o(irq_pending), .wake_o(wake),
      .dispatch_i(dispatch), .vec_req_i(vec_req),
      .vector_o(vector), .ime_o(ime), .irq_state(irq_state)
   );

   // reference model: architectural state only
   logic [7:0] if_m, ie_m;
   bit         ime_m, in_push_m;
   int         ei_at;   // cycle at which a pending EI takes effect, -1 if none
   int         cyc;

   logic [W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // monitor: outputs are combinational, so every cycle presents a result
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("rdata",   16'(bus_rdata),   16'(e.rdata));
         chk("hit",     16'(bus_hit),     16'(e.hit));
         chk("pending", 16'(irq_pending), 16'(e.pending));
         chk("wake",    16'(wake),        16'(e.wake));
         chk("ime",     16'(ime),         16'(e.ime));
         chk("vector",  vector,           e.vector);
         chk("state",   16'(irq_state),   16'(e.state));
      end
   end

   // driver: apply one cycle of inputs, predict, then advance the model
   task automatic step(input bit r, input logic [N-1:0] ir, input logic [15:0] a,
                       input logic [7:0] wd, input bit we, input bit ei, input bit di,
                       input bit rt, input bit dsp, input bit vr);
      exp_t e;
      logic [7:0] act_m, wr_if;
      int   k;
      bit   accept;
      reset = r; irq = ir; bus_addr = a; bus_wdata = wd; bus_we = we;
      ei_req = ei; di_req = di; reti_req = rt; dispatch = dsp; vec_req = vr;

      act_m = if_m & ie_m & MASK;
      k = -1;
      for (int i = N - 1; i >= 0; i--) if (act_m[i]) k = i;

      e.rdata   = (a == A_IF) ? (if_m | ~MASK) : (a == A_IE) ? ie_m : 8'hFF;
      e.hit     = (a == A_IF) || (a == A_IE);
      e.wake    = (act_m != 0);
      e.pending = ime_m && (act_m != 0);
      e.ime     = ime_m;
      e.state   = in_push_m;
      e.vector  = (in_push_m && vr && k >= 0) ? 16'(VBASE + k * VSTRIDE) : 16'h0000;
      exp_q.push_back(e);

      @(posedge clk);
      if (r) begin
         if_m = 0; ie_m = 0; ime_m = 0; in_push_m = 0; ei_at = -1;
      end else begin
         accept = !in_push_m && dsp && e.pending;
         wr_if  = (we && a == A_IF) ? (wd & MASK) : if_m;
         if (in_push_m && vr && k >= 0) wr_if[k] = 1'b0;
         if_m = wr_if | 8'(ir);
         if (we && a == A_IE) ie_m = wd;
         if (di || accept) begin
            ime_m = 0; ei_at = -1;
         end else begin
            if (ei) begin
               if (EID == 0) ime_m = 1; else ei_at = cyc + EID;
            end else if (ei_at == cyc) begin
               ime_m = 1; ei_at = -1;
            end
            if (rt) ime_m = 1;
         end
         if (accept) in_push_m = 1;
         else if (in_push_m && vr) in_push_m = 0;
      end
      cyc++;
      #1;
   endtask

   task automatic idle(input logic [15:0] a);
      step(0, '0, a, 8'h00, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      logic [N-1:0] r_irq;
      logic [15:0]  r_addr;
      bit r_rst, r_vec;
      if_m = 0; ie_m = 0; ime_m = 0; in_push_m = 0; ei_at = -1; cyc = 0;
      reset = 1; irq = '0; bus_addr = 16'h0000; bus_wdata = 8'h00; bus_we = 0;
      ei_req = 0; di_req = 0; reti_req = 0; dispatch = 0; vec_req = 0;
      repeat (2) @(posedge clk);
      #1;

      // reset values
      step(1, '0, A_IF, 8'h00, 0, 0, 0, 0, 0, 0);
      idle(A_IF);
      idle(A_IE);

      // wake without IME, then delayed EI
      step(0, '0, A_IE, 8'h05, 1, 0, 0, 0, 0, 0);
      step(0, 5'b00100, A_IF, 8'h00, 0, 0, 0, 0, 0, 0);
      idle(A_IF);
      step(0, '0, A_IF, 8'h00, 0, 1, 0, 0, 0, 0);
      idle(A_IF);
      idle(A_IF);
      idle(A_IF);

      // dispatch line 1 from IF=06, IE=1F
      step(0, '0, A_IF, 8'h06, 1, 0, 1, 0, 0, 0);
      step(0, '0, A_IE, 8'h1F, 1, 0, 0, 1, 0, 0);
      step(0, '0, A_IF, 8'h00, 0, 0, 0, 0, 1, 0);
      step(0, '0, A_IF, 8'h00, 0, 0, 0, 0, 0, 1);
      idle(A_IF);

      // IE cleared during PUSH: null vector, IF untouched
      step(0, '0, A_IF, 8'h00, 0, 0, 0, 1, 0, 0);
      step(0, '0, A_IF, 8'h00, 0, 0, 0, 0, 1, 0);
      step(0, '0, A_IE, 8'h00, 1, 0, 0, 0, 0, 0);
      step(0, '0, A_IF, 8'h00, 0, 0, 0, 0, 0, 1);
      idle(A_IF);

      // write vs request collision, EI+DI together
      step(0, 5'b01000, A_IF, 8'h00, 1, 0, 0, 0, 0, 0);
      idle(A_IF);
      step(0, '0, A_IE, 8'h08, 1, 1, 1, 0, 0, 0);
      idle(A_IF);
      idle(A_IF);

      // reset while in PUSH
      step(0, '0, A_IF, 8'h00, 0, 0, 0, 1, 0, 0);
      step(0, '0, A_IF, 8'h00, 0, 0, 0, 0, 1, 0);
      step(1, '0, A_IF, 8'h00, 0, 0, 0, 0, 0, 0);
      idle(A_IF);
      step(0, '0, A_IF, 8'h00, 0, 0, 0, 0, 0, 1);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         r_rst = ($urandom_range(0, 199) == 0);
         r_irq = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
         case ($urandom_range(0, 4))
            0, 1:    r_addr = A_IF;
            2, 3:    r_addr = A_IE;
            default: r_addr = 16'($urandom);
         endcase
         r_vec = in_push_m && !r_rst && ($urandom_range(0, 1) == 1);
         step(r_rst, r_irq, r_addr, 8'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0), r_vec);
      end

      idle(16'h0000);
      @(negedge clk);
      #1;
      chk("queue_drained", 16'(exp_q.size()), 16'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
